// File: rtl/uart_pkg.sv
// Shared UART types and helpers.
// Receiver state encoding and baud divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    // Rounded clock cycles per oversample tick
    function automatic int baud_div(input int clk, input int baud, input int os);
        return (clk + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick divider.
// Shared by the UART receiver and transmitter.
module uart_baud_gen #(
    parameter int Div = 54
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = (Div > 1) ? $clog2(Div) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CW'(Div - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling 8N1 UART receiver, LSB first, with majority-vote bit
// recovery, error pulses and RTS flow control.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DataLength      = 8,
    parameter int OverSample      = 8,
    parameter int BaudRate        = 115200,
    parameter int SystemClockFreq = 50_000_000,
    parameter int FlowControl     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx,
    input  logic                  i_fifo_full,
    output logic [DataLength-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_frame_err,
    output logic                  o_break,
    output logic                  o_overrun,
    output logic                  o_busy,
    output logic                  o_rts
);

    localparam int Div = baud_div(SystemClockFreq, BaudRate, OverSample);
    localparam int TW  = $clog2(OverSample + 2);
    localparam int IW  = $clog2(DataLength + 1);

    logic                  w_tick;
    logic [1:0]            r_sync;
    logic                  w_rx_s;
    rx_state_e             r_state, w_state_nx;
    logic [TW-1:0]         r_tcnt, w_tcnt_nx, w_t;
    logic [IW-1:0]         r_bit_idx, w_bit_idx_nx;
    logic [1:0]            r_votes, w_votes_nx;
    logic                  w_maj;
    logic [DataLength-1:0] r_shift, w_shift_nx;
    logic [DataLength-1:0] r_rx_data, w_rx_data_nx;
    logic                  r_valid, w_valid_nx;
    logic                  r_ferr, w_ferr_nx;
    logic                  r_brk, w_brk_nx;
    logic                  r_ovr, w_ovr_nx;
    logic                  r_rts;

    uart_baud_gen #(
        .Div(Div)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    assign w_rx_s = r_sync[1];
    assign w_t    = r_tcnt + 1'b1;
    // Votes hold ticks c-1 and c; the live sample is tick c+1
    assign w_maj  = (r_votes[1] & r_votes[0]) |
                    (r_votes[1] & w_rx_s) |
                    (r_votes[0] & w_rx_s);

    always_comb begin
        w_state_nx   = r_state;
        w_tcnt_nx    = r_tcnt;
        w_bit_idx_nx = r_bit_idx;
        w_votes_nx   = r_votes;
        w_shift_nx   = r_shift;
        w_rx_data_nx = r_rx_data;
        w_valid_nx   = 1'b0;
        w_ferr_nx    = 1'b0;
        w_brk_nx     = 1'b0;
        w_ovr_nx     = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nx = START;
                        w_tcnt_nx  = '0;
                    end
                end
                START: begin
                    w_tcnt_nx = w_t;
                    if (w_t == TW'(OverSample / 2)) begin
                        w_tcnt_nx = '0;
                        if (w_rx_s) begin
                            w_state_nx = IDLE;
                        end else begin
                            w_state_nx   = DATA;
                            w_bit_idx_nx = '0;
                        end
                    end
                end
                DATA, STOP: begin
                    w_tcnt_nx = w_t;
                    if (w_t == TW'(OverSample - 1) || w_t == TW'(OverSample)) begin
                        w_votes_nx = {r_votes[0], w_rx_s};
                    end
                    if (w_t == TW'(OverSample + 1)) begin
                        // Next centre is OverSample ticks after this one
                        w_tcnt_nx = TW'(1);
                        if (r_state == DATA) begin
                            w_shift_nx   = {w_maj, r_shift[DataLength-1:1]};
                            w_bit_idx_nx = r_bit_idx + 1'b1;
                            if (r_bit_idx == IW'(DataLength - 1)) begin
                                w_state_nx = STOP;
                            end
                        end else if (w_maj) begin
                            w_state_nx = IDLE;
                            if (i_fifo_full) begin
                                w_ovr_nx = 1'b1;
                            end else begin
                                w_valid_nx   = 1'b1;
                                w_rx_data_nx = r_shift;
                            end
                        end else begin
                            w_state_nx = WAIT_IDLE;
                            w_ferr_nx  = 1'b1;
                            w_brk_nx   = (r_shift == '0);
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (w_rx_s) begin
                        w_state_nx = IDLE;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_tcnt    <= '0;
            r_bit_idx <= '0;
            r_votes   <= '0;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_brk     <= 1'b0;
            r_ovr     <= 1'b0;
            r_rts     <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_tcnt    <= w_tcnt_nx;
            r_bit_idx <= w_bit_idx_nx;
            r_votes   <= w_votes_nx;
            r_shift   <= w_shift_nx;
            r_rx_data <= w_rx_data_nx;
            r_valid   <= w_valid_nx;
            r_ferr    <= w_ferr_nx;
            r_brk     <= w_brk_nx;
            r_ovr     <= w_ovr_nx;
            r_rts     <= ~i_fifo_full;
        end
    end

    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_valid;
    assign o_frame_err = r_ferr;
    assign o_break     = r_brk;
    assign o_overrun   = r_ovr;
    assign o_busy      = (r_state != IDLE);
    assign o_rts       = (FlowControl != 0) ? r_rts : 1'b1;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial frames driven
// asynchronously, outcomes checked against an event queue model.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam realtime BIT = 8680.6;
    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_BRK   = 2;
    localparam int K_OVR   = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       full  = 1'b0;
    logic [7:0] rx_data;
    logic       valid, ferr, brk, ovr, busy, rts;

    int         tests = 0;
    int         fails = 0;
    int         qk[$];
    logic [7:0] qd[$];
    logic [7:0] got[$];
    logic [7:0] m_last = 8'h00;
    logic       m_rts  = 1'b1;
    int         n_valid = 0, n_ferr = 0, n_brk = 0, n_ovr = 0;

    always #10 clk = ~clk;

    uart_rx_core dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx       (rx),
        .i_fifo_full(full),
        .o_rx_data  (rx_data),
        .o_rx_valid (valid),
        .o_frame_err(ferr),
        .o_break    (brk),
        .o_overrun  (ovr),
        .o_busy     (busy),
        .o_rts      (rts)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RTS is the fullness flag inverted, one clock late
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_rts <= 1'b1;
        else        m_rts <= ~full;
    end

    always @(negedge clk) begin : compare
        int k;
        int ek;
        logic [7:0] ed;
        if (!rst_n) begin
            m_last = 8'h00;
        end else begin
            chk("rts", rts, m_rts);
            if (valid || ferr || brk || ovr) begin
                k = valid ? K_VALID : ovr ? K_OVR : brk ? K_BRK : K_FERR;
                chk("no_coincide", valid && (ferr || brk || ovr), 0);
                chk("brk_with_ferr", brk && !ferr, 0);
                if (valid) begin n_valid++; got.push_back(rx_data); end
                if (ferr) n_ferr++;
                if (brk)  n_brk++;
                if (ovr)  n_ovr++;
                if (qk.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected: got event %0d data %0h expected none", k, rx_data);
                end else begin
                    ek = qk.pop_front();
                    ed = qd.pop_front();
                    chk("event_kind", k, ek);
                    if (valid) begin
                        chk("event_data", rx_data, ed);
                        m_last = ed;
                    end
                end
            end else begin
                chk("data_hold", rx_data, m_last);
            end
        end
    end

    task automatic drive(input logic [7:0] d, input logic stop, input realtime per);
        rx = 1'b0;
        #(per);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(per);
        end
        rx = stop;
        #(per);
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input realtime per);
        if (stop) begin
            qk.push_back(full ? K_OVR : K_VALID);
            qd.push_back(full ? 8'h00 : d);
        end else begin
            qk.push_back(d == 8'h00 ? K_BRK : K_FERR);
            qd.push_back(8'h00);
        end
        drive(d, stop, per);
    endtask

    task automatic drain(input string name);
        repeat (40) @(posedge clk);
        chk(name, qk.size(), 0);
        qk.delete();
        qd.delete();
    endtask

    task automatic gap();
        #(BIT / 2);
        #($urandom_range(0, 500));
    endtask

    function automatic logic [7:0] last_got();
        if (got.size() == 0) return 8'hxx;
        return got[got.size() - 1];
    endfunction

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] d;
        logic       s;
        #105;
        chk("rst_valid", valid, 0);
        chk("rst_errs", {ferr, brk, ovr}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rts", rts, 1);
        chk("rst_data", rx_data, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        fork
            send(8'hA5, 1'b1, BIT);
            begin #(BIT * 5); chk("t1_busy_mid", busy, 1); end
        join
        drain("t1_drain");
        chk("t1_nvalid", n_valid, 1);
        chk("t1_byte", last_got(), 8'hA5);
        chk("t1_noerr", n_ferr + n_brk + n_ovr, 0);
        chk("t1_busy_end", busy, 0);

        send(8'h00, 1'b1, BIT);
        send(8'hFF, 1'b1, BIT);
        send(8'h5A, 1'b1, BIT);
        send(8'h3C, 1'b1, BIT);
        drain("t2_drain");
        chk("t2_nvalid", got.size(), 5);
        chk("t2_seq", {got[1], got[2], got[3], got[4]}, 32'h00FF5A3C);

        gap();
        rx = 1'b0;
        #3000;
        rx = 1'b1;
        #(BIT * 2);
        drain("t3_drain");
        chk("t3_busy", busy, 0);
        chk("t3_noevent", n_valid + n_ferr + n_brk + n_ovr, 5);

        send(8'h81, 1'b0, BIT);
        gap();
        drain("t4_ferr_drain");
        chk("t4_ferr_only", {n_ferr, n_brk}, {32'd1, 32'd0});
        qk.push_back(K_BRK);
        qd.push_back(8'h00);
        rx = 1'b0;
        #(BIT * 20);
        rx = 1'b1;
        gap();
        drain("t4_brk_drain");
        chk("t4_brk_pair", {n_ferr, n_brk}, {32'd2, 32'd1});
        send(8'h42, 1'b1, BIT);
        drain("t4_42_drain");
        chk("t4_42", last_got(), 8'h42);

        gap();
        @(negedge clk);
        full = 1'b1;
        @(negedge clk);
        chk("t5_rts_low", rts, 0);
        send(8'h33, 1'b1, BIT);
        drain("t5_ovr_drain");
        chk("t5_novr", n_ovr, 1);
        chk("t5_nvalid", n_valid, 6);
        @(negedge clk);
        full = 1'b0;
        gap();
        send(8'h34, 1'b1, BIT);
        drain("t5_34_drain");
        chk("t5_34", last_got(), 8'h34);

        gap();
        send(8'h55, 1'b1, 8507.0);
        gap();
        send(8'hAA, 1'b1, 8854.0);
        drain("t6_rate_drain");
        chk("t6_rate", {got[got.size() - 2], last_got()}, 16'h55AA);

        gap();
        fork
            drive(8'hFF, 1'b1, BIT);
            begin
                #(BIT * 3.3);
                rst_n = 1'b0;
                #200;
                rst_n = 1'b1;
                @(negedge clk);
                chk("t6_rst_busy", busy, 0);
                chk("t6_rst_data", rx_data, 0);
            end
        join
        gap();
        drain("t6_rst_drain");
        chk("t6_rst_nopulse", n_valid + n_ferr + n_brk + n_ovr, 13);
        send(8'hC3, 1'b1, BIT);
        drain("t6_c3_drain");
        chk("t6_c3", last_got(), 8'hC3);

        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            gap();
            @(negedge clk);
            full = ($urandom_range(0, 3) == 0);
            send(d, s, realtime'($urandom_range(8600, 8760)));
            drain("rand_drain");
            @(negedge clk);
            full = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
